// File: rtl/wb_queue_if.sv
// Bus bundle for the write-back queue: producer write port, register-file
// write port, operand read/forward paths and occupancy.
interface wb_queue_if #(
   parameter int DEPTH = 4
);
   logic                       in_valid;
   logic [4:0]                 in_reg;
   logic [63:0]                in_data;
   logic                       in_ready;
   logic                       RegWrite;
   logic [4:0]                 WriteRegister;
   logic [63:0]                WriteData;
   logic [4:0]                 ReadRegister1;
   logic [4:0]                 ReadRegister2;
   logic [63:0]                RfData1;
   logic [63:0]                RfData2;
   logic [63:0]                ReadData1;
   logic [63:0]                ReadData2;
   logic [$clog2(DEPTH):0]     count;

   modport slave (
      input  in_valid, in_reg, in_data, ReadRegister1, ReadRegister2, RfData1, RfData2,
      output in_ready, RegWrite, WriteRegister, WriteData, ReadData1, ReadData2, count
   );

   modport master (
      output in_valid, in_reg, in_data, ReadRegister1, ReadRegister2, RfData1, RfData2,
      input  in_ready, RegWrite, WriteRegister, WriteData, ReadData1, ReadData2, count
   );
endinterface

// File: rtl/wb_queue.sv
// Circular write-back queue in front of the register file, draining one entry
// per cycle and forwarding pending writes onto the operand read paths.
module wb_queue #(
   parameter int DEPTH = 4
) (
   input logic        clk,
   input logic        reset,
   wb_queue_if.slave  bus
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [PW-1:0] head_r;
   logic [PW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [4:0]    reg_mem_r  [DEPTH];
   logic [63:0]   data_mem_r [DEPTH];
   logic          ready_s;
   logic          push_s;
   logic          pop_s;
   logic [63:0]   rd1_s;
   logic [63:0]   rd2_s;

   // Newest-wins lookup over occupied entries, oldest (head) to newest.
   function automatic logic [63:0] forward(input logic [4:0] rr, input logic [63:0] rf,
                                           input logic [PW-1:0] head, input logic [CW-1:0] cnt);
      logic [63:0]   res;
      logic [PW-1:0] idx;
      res = rf;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < cnt) && (reg_mem_r[idx] == rr)) begin
            res = data_mem_r[idx];
         end else begin
            res = res;
         end
      end
      if (rr == 5'd31) begin
         res = 64'd0;
      end else begin
         res = res;
      end
      return res;
   endfunction

   // Handshake and drain decisions; X31 writes are accepted but never stored.
   always_comb begin
      ready_s = 1'b0;
      push_s  = 1'b0;
      pop_s   = 1'b0;
      if (reset) begin
         ready_s = 1'b0;
         pop_s   = 1'b0;
      end else begin
         ready_s = (count_r < CW'(DEPTH));
         pop_s   = (count_r != {CW{1'b0}});
      end
      push_s = bus.in_valid && ready_s && (bus.in_reg != 5'd31);
   end

   // Operand correction for both read ports.
   always_comb begin
      rd1_s = forward(bus.ReadRegister1, bus.RfData1, head_r, count_r);
      rd2_s = forward(bus.ReadRegister2, bus.RfData2, head_r, count_r);
   end

   // Pointer and occupancy update; reset overrides push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_r  <= {PW{1'b0}};
         tail_r  <= {PW{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            tail_r <= tail_r + PW'(1);
         end
         if (pop_s) begin
            head_r <= head_r + PW'(1);
         end
         count_r <= count_r + CW'(push_s) - CW'(pop_s);
      end
   end

   // Entry storage; contents only matter while covered by count.
   always_ff @(posedge clk) begin
      if (push_s) begin
         reg_mem_r[tail_r]  <= bus.in_reg;
         data_mem_r[tail_r] <= bus.in_data;
      end
   end

   assign bus.in_ready      = ready_s;
   assign bus.RegWrite      = pop_s;
   assign bus.WriteRegister = pop_s ? reg_mem_r[head_r]  : 5'd0;
   assign bus.WriteData     = pop_s ? data_mem_r[head_r] : 64'd0;
   assign bus.ReadData1     = rd1_s;
   assign bus.ReadData2     = rd2_s;
   assign bus.count         = count_r;
endmodule
